// File: rtl/hit_event_arbiter.sv
// hit_event_arbiter: captures per-lane hit pulses with a millisecond timestamp and
// serialises them round-robin onto a valid/ready event port; owns the game timebase.
module hit_event_arbiter #(
    parameter int N_LANES    = 4,
    parameter int LANE_W     = 2,
    parameter int CLK_PER_MS = 50_000,
    parameter int TS_W       = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Enable,
    input  logic [N_LANES-1:0] i_Pulse,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [LANE_W-1:0]  o_Lane,
    output logic [TS_W-1:0]    o_Time,
    output logic [TS_W-1:0]    o_Now,
    output logic [7:0]         o_Drop_Cnt,
    output logic [N_LANES-1:0] o_Pending
);
    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam int SUM_W = LANE_W + 1;
    localparam logic [SUM_W-1:0] N_SUM = SUM_W'(N_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
    localparam int CNT_W = $clog2(N_LANES + 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0]         state;
    logic [PRE_W-1:0]   prescale;
    logic [LANE_W-1:0]  rr_ptr;
    logic [TS_W-1:0]    ts [N_LANES];
    logic               gnt_vld;
    logic [LANE_W-1:0]  gnt_lane;
    logic [N_LANES-1:0] gnt_mask;
    logic [N_LANES-1:0] overrun;
    logic [CNT_W-1:0]   overrun_cnt;

    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [CNT_W-1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + 9'(inc);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Grant decision: first pending lane at or after rr_ptr, modulo N_LANES
    always_comb begin
        logic [SUM_W-1:0]  sum;
        logic [LANE_W-1:0] idx;
        gnt_vld  = 1'b0;
        gnt_lane = '0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sum = {1'b0, rr_ptr} + SUM_W'(i);
            if (sum >= N_SUM) begin
                sum = sum - N_SUM;
            end
            idx = sum[LANE_W-1:0];
            if (!gnt_vld && o_Pending[idx]) begin
                gnt_vld  = 1'b1;
                gnt_lane = idx;
            end
        end
        gnt_vld  = gnt_vld && (state == S_IDLE) && i_Enable;
        gnt_mask = gnt_vld ? (N_LANES'(1) << gnt_lane) : '0;
    end

    // A lane granted this cycle frees its slot, so a same-cycle re-hit is not an overrun
    always_comb begin
        overrun     = i_Enable ? (i_Pulse & o_Pending & ~gnt_mask) : '0;
        overrun_cnt = '0;
        for (int i = 0; i < N_LANES; i++) begin
            overrun_cnt = overrun_cnt + CNT_W'(overrun[i]);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            prescale <= '0;
            o_Now    <= '0;
        end else if (!i_Enable) begin
            prescale <= '0;
            o_Now    <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            o_Now    <= o_Now + TS_W'(1);
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Pending <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                ts[k] <= '0;
            end
        end else if (!i_Enable) begin
            o_Pending <= '0;
        end else begin
            o_Pending <= (o_Pending & ~gnt_mask) | i_Pulse;
            for (int k = 0; k < N_LANES; k++) begin
                if (i_Pulse[k] && !overrun[k]) begin
                    ts[k] <= o_Now;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Drop_Cnt <= '0;
        end else if (i_Enable) begin
            o_Drop_Cnt <= sat_add(o_Drop_Cnt, overrun_cnt);
        end
    end

    // Event port: o_Lane/o_Time frozen while presenting until accepted
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            o_Valid <= 1'b0;
            o_Lane  <= '0;
            o_Time  <= '0;
            rr_ptr  <= '0;
        end else if (!i_Enable) begin
            state   <= S_IDLE;
            o_Valid <= 1'b0;
            rr_ptr  <= '0;
        end else if (state == S_IDLE) begin
            if (gnt_vld) begin
                state   <= S_PRESENT;
                o_Valid <= 1'b1;
                o_Lane  <= gnt_lane;
                o_Time  <= ts[gnt_lane];
                rr_ptr  <= (gnt_lane == LAST_LANE) ? '0 : gnt_lane + LANE_W'(1);
            end
        end else if (i_Ready) begin
            state   <= S_IDLE;
            o_Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hit_event_arbiter.sv
// Bench for hit_event_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of timebase, slots, arbitration and drops.
module tb_hit_event_arbiter;
    localparam int N   = 4;
    localparam int LW  = 2;
    localparam int CPM = 4;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [N-1:0]  pulse;
    logic          ready;
    logic          o_valid;
    logic [LW-1:0] o_lane;
    logic [TW-1:0] o_time;
    logic [TW-1:0] o_now;
    logic [7:0]    o_drop;
    logic [N-1:0]  o_pend;

    logic          w_valid;
    logic [LW-1:0] w_lane;
    logic [3:0]    w_time;
    logic [3:0]    w_now;
    logic [7:0]    w_drop;
    logic [N-1:0]  w_pend;

    hit_event_arbiter #(.N_LANES(N), .LANE_W(LW), .CLK_PER_MS(CPM), .TS_W(TW)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Pulse(pulse),
        .o_Valid(o_valid), .i_Ready(ready), .o_Lane(o_lane), .o_Time(o_time),
        .o_Now(o_now), .o_Drop_Cnt(o_drop), .o_Pending(o_pend)
    );

    hit_event_arbiter #(.N_LANES(N), .LANE_W(LW), .CLK_PER_MS(2), .TS_W(4)) u_wrap (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(1'b1), .i_Pulse(4'b0000),
        .o_Valid(w_valid), .i_Ready(1'b0), .o_Lane(w_lane), .o_Time(w_time),
        .o_Now(w_now), .o_Drop_Cnt(w_drop), .o_Pending(w_pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time = enabled cycles / CPM, one slot per lane, event queue of depth one
    int m_cycles;
    bit m_pend [N];
    int m_ts   [N];
    bit m_valid;
    int m_lane, m_time, m_rr, m_drop;
    int x_ts, y_ts;

    function automatic int m_now();
        return (m_cycles / CPM) % (1 << TW);
    endfunction

    task automatic model_reset();
        m_cycles = 0; m_valid = 0; m_lane = 0; m_time = 0; m_rr = 0; m_drop = 0;
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0;
            m_ts[k]   = 0;
        end
    endtask

    task automatic model_step(input bit e, input logic [N-1:0] p, input bit r);
        int nowc;
        int g;
        nowc = m_now();
        if (!e) begin
            m_cycles = 0; m_valid = 0; m_rr = 0;
            for (int k = 0; k < N; k++) m_pend[k] = 0;
            return;
        end
        m_cycles++;
        g = -1;
        if (!m_valid) begin
            for (int i = 0; i < N; i++)
                if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
        end else if (r) begin
            m_valid = 0;
        end
        if (g >= 0) begin
            m_valid = 1; m_lane = g; m_time = m_ts[g]; m_pend[g] = 0; m_rr = (g + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            if (p[k]) begin
                if (m_pend[k]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else begin
                    m_pend[k] = 1;
                    m_ts[k]   = nowc;
                end
            end
        end
    endtask

    function automatic logic [63:0] model_pack();
        logic [N-1:0] pv;
        for (int k = 0; k < N; k++) pv[k] = m_pend[k];
        return {17'b0, m_valid, LW'(m_lane), TW'(m_time), TW'(m_now()), 8'(m_drop), pv};
    endfunction

    function automatic logic [63:0] dut_pack();
        return {17'b0, o_valid, o_lane, o_time, o_now, o_drop, o_pend};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cycle(input logic [N-1:0] p, input bit r, input bit e);
        pulse = p; ready = r; en = e;
        @(posedge clk);
        model_step(e, p, r);
        #1;
        chk("cycle", dut_pack(), model_pack());
    endtask

    task automatic wait_now(input int v);
        for (int n = 0; n < 200 && o_now != TW'(v); n++) cycle('0, 1'b0, 1'b1);
        chk("wait_now", 64'(o_now), 64'(v));
    endtask

    task automatic rand_phase(input int n_cyc);
        logic [N-1:0] p;
        for (int i = 0; i < n_cyc; i++) begin
            p = N'($urandom & $urandom & $urandom);
            cycle(p, 1'($urandom_range(0, 1)), $urandom_range(0, 49) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pulse = '0; ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_pack(), 64'h0);
        rst_n = 1'b1;
        repeat (CPM) cycle('0, 1'b0, 1'b1);
        chk("first_ms", 64'(o_now), 64'd1);

        // Single hit on lane 2 at o_Now = 5, held until accepted
        wait_now(5);
        cycle(4'b0100, 1'b0, 1'b1);
        chk("hit_pend", {o_valid, o_pend}, {1'b0, 4'b0100});
        cycle('0, 1'b0, 1'b1);
        chk("hit_evt", {o_valid, o_lane, o_time}, {1'b1, 2'd2, 16'd5});
        for (int i = 0; i < 20; i++) begin
            cycle('0, 1'b0, 1'b1);
            chk("hit_hold", {o_valid, o_lane, o_time}, {1'b1, 2'd2, 16'd5});
        end
        cycle('0, 1'b1, 1'b1);
        chk("hit_accept", {o_valid, o_pend}, {1'b0, 4'b0000});

        // Round-robin from rr_ptr = 0, late arrivals on lanes 0 and 2
        cycle('0, 1'b0, 1'b0);
        chk("rr_flush", {o_valid, o_pend, o_now}, {1'b0, 4'b0000, 16'd0});
        cycle(4'b1011, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        chk("rr_g0", {o_valid, o_lane}, {1'b1, 2'd0});
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        chk("rr_g1", {o_valid, o_lane}, {1'b1, 2'd1});
        cycle(4'b0101, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        chk("rr_g2", {o_valid, o_lane}, {1'b1, 2'd2});
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        chk("rr_g3", {o_valid, o_lane}, {1'b1, 2'd3});
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        chk("rr_g0b", {o_valid, o_lane}, {1'b1, 2'd0});
        cycle('0, 1'b1, 1'b1);

        // Overrun: lane 0 hits at 3, 4, 6 while lane 1 blocks the port
        cycle('0, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        wait_now(3);
        cycle(4'b0001, 1'b0, 1'b1);
        wait_now(4);
        cycle(4'b0001, 1'b0, 1'b1);
        wait_now(6);
        cycle(4'b0001, 1'b0, 1'b1);
        chk("ovr_drop", 64'(o_drop), 64'd2);
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);
        chk("ovr_evt", {o_valid, o_lane, o_time}, {1'b1, 2'd0, 16'd3});
        cycle('0, 1'b1, 1'b1);

        // Same-cycle re-hit on lane 1 when it is granted
        cycle(4'b0100, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        x_ts = m_now();
        cycle(4'b0010, 1'b0, 1'b1);
        repeat (8) cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b1);
        y_ts = m_now();
        cycle(4'b0010, 1'b0, 1'b1);
        chk("rehit_evt", {o_valid, o_lane, o_time}, {1'b1, 2'd1, TW'(x_ts)});
        chk("rehit_pend", {o_pend, o_drop}, {4'b0010, 8'd2});
        cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);
        chk("rehit_evt2", {o_valid, o_lane, o_time}, {1'b1, 2'd1, TW'(y_ts)});
        cycle('0, 1'b1, 1'b1);

        // Drop counter saturation, then enable drop while presenting
        repeat (305) cycle(4'b1000, 1'b0, 1'b1);
        chk("drop_sat", 64'(o_drop), 64'd255);
        cycle('0, 1'b0, 1'b0);
        chk("en_drop", {o_valid, o_pend, o_now, o_drop}, {1'b0, 4'b0000, 16'd0, 8'd255});

        rand_phase(1500);

        // Asynchronous reset in the middle of a presentation
        cycle(4'b0001, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", dut_pack(), 64'h0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (CPM) cycle('0, 1'b0, 1'b1);
        chk("post_rst_ms", 64'(o_now), 64'd1);

        rand_phase(1500);

        // Timebase wrap on the narrow instance
        for (int n = 0; n < 100 && w_now != 4'd15; n++) cycle('0, 1'b0, 1'b1);
        chk("wrap15", 64'(w_now), 64'd15);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        chk("wrap0", 64'(w_now), 64'd0);
        chk("wrap_idle", {w_valid, w_lane, w_time, w_drop, w_pend}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
